// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Holds the frame-parsing state encoding and the word/checksum constants.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    SUM,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [7:0] CHECKSUM_OK = 8'h00;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into little-endian 32-bit words.
// word_valid is raised combinationally with the 4th byte so the caller can register the write.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane;
  logic [23:0] partial;

  // Earlier bytes shift down so the first byte of a word ends up in bits 7:0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane    <= 2'd0;
      partial <= 24'd0;
    end else if (byte_valid) begin
      lane    <= lane + 2'd1;
      partial <= {byte_data, partial[23:8]};
    end
  end

  always_comb begin
    word_valid = byte_valid && (lane == LAST_LANE);
    word       = {byte_data, partial};
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: parses a length-prefixed, checksummed byte frame,
// writes the words to memory and releases the CPU reset only after a good load.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state, next_state;

  logic                accept;
  logic                restart;
  logic                word_valid;
  logic [31:0]         word;
  logic [7:0]          len_lo;
  logic [7:0]          sum;
  logic [7:0]          sum_next;
  logic [15:0]         full_len;
  logic [ADDR_WIDTH:0] len_words;
  logic [ADDR_WIDTH:0] word_idx;
  logic [ADDR_WIDTH:0] word_idx_next;

  assign accept        = in_valid && in_ready;
  assign restart       = start && ((state == DONE) || (state == ERR));
  assign sum_next      = sum + in_data;
  assign full_len      = {in_data, len_lo};
  assign word_idx_next = word_idx + ONE;

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (accept && (state == DATA)),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LEN0;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_reset  = 1'b1;
    case (state)
      LEN0: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) next_state = LEN1;
      end
      LEN1: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (32'(full_len) > MAX_WORDS) next_state = ERR;
          else if (full_len == 16'd0)    next_state = SUM;
          else                           next_state = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_valid && (word_idx_next == len_words)) next_state = SUM;
      end
      SUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) next_state = (sum_next == CHECKSUM_OK) ? DONE : ERR;
      end
      DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) next_state = LEN0;
      end
      ERR: begin
        error = 1'b1;
        if (start) next_state = LEN0;
      end
      default: next_state = LEN0;
    endcase
  end

  // A restart from DONE/ERR clears the datapath exactly like reset does.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      len_lo    <= 8'd0;
      sum       <= 8'd0;
      len_words <= '0;
      word_idx  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= word_valid;
      if (accept) sum <= sum_next;
      if (accept && (state == LEN0)) len_lo <= in_data;
      if (accept && (state == LEN1)) len_words <= full_len[ADDR_WIDTH:0];
      if (word_valid) begin
        mem_addr  <= word_idx[ADDR_WIDTH-1:0];
        mem_wdata <= word;
        word_idx  <= word_idx_next;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a frame-level model predicts writes and outcome,
// a per-cycle compare process checks every write and the status-output rules.
module tb_program_loader;

  localparam int ADDR_WIDTH = 12;
  localparam int MAX_WORDS  = 2 ** ADDR_WIDTH;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  start;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0]  frame[$];
  logic [31:0] exp_writes[$];
  int          exp_addrs[$];
  logic        exp_done;
  logic        exp_error;

  int          writes_seen = 0;
  int          last_addr   = 0;
  logic [31:0] last_data   = 32'd0;
  int          base;

  program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .start     (start),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: parse the length, slice the data into words, verify the checksum.
  task automatic build_model();
    int len;
    logic [7:0] s;
    exp_writes.delete();
    exp_addrs.delete();
    len = int'({frame[1], frame[0]});
    if (len > MAX_WORDS) begin
      exp_done  = 1'b0;
      exp_error = 1'b1;
    end else begin
      for (int i = 0; i < len; i++) begin
        exp_writes.push_back({frame[2+4*i+3], frame[2+4*i+2], frame[2+4*i+1], frame[2+4*i]});
        exp_addrs.push_back(i);
      end
      s = 8'h00;
      for (int j = 0; j < 3 + 4 * len; j++) s = s + frame[j];
      exp_done  = (s == 8'h00);
      exp_error = !exp_done;
    end
  endtask

  task automatic applyStimulus(input bit gapped);
    foreach (frame[k]) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frame[k];
      checkOutput("in_ready_during_frame", in_ready, 1'b1);
      if (gapped) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hFF;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart_busy", busy, 1'b1);
    checkOutput("restart_cpu_reset", cpu_reset, 1'b1);
    checkOutput("restart_in_ready", in_ready, 1'b1);
    checkOutput("restart_error", error, 1'b0);
    checkOutput("restart_done", done, 1'b0);
  endtask

  task automatic check_outcome(input string name);
    checkOutput({name, "_done"}, done, exp_done);
    checkOutput({name, "_error"}, error, exp_error);
    checkOutput({name, "_drained"}, exp_writes.size(), 0);
    checkOutput({name, "_in_ready_after"}, in_ready, 1'b0);
  endtask

  // Every write is matched against the model; status outputs follow the load outcome.
  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_writes.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %h expected no write", mem_addr, mem_wdata);
      end else begin
        checkOutput("write_addr", mem_addr, exp_addrs.pop_front());
        checkOutput("write_data", mem_wdata, exp_writes.pop_front());
      end
      writes_seen++;
      last_addr = int'(mem_addr);
      last_data = mem_wdata;
    end
    checkOutput("done_error_exclusive", done && error, 1'b0);
    checkOutput("cpu_reset_rule", cpu_reset, !done);
    checkOutput("busy_rule", busy, !(done || error));
    checkOutput("ready_rule", in_ready, busy);
  end

  initial begin
    logic [7:0] s;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    @(negedge clk);
    checkOutput("reset_cpu_reset", cpu_reset, 1'b1);
    checkOutput("reset_busy", busy, 1'b1);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_error", error, 1'b0);
    checkOutput("reset_mem_we", mem_we, 1'b0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] single word");
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB};
    build_model();
    checkOutput("s1_model_word", exp_writes[0], 32'h12345678);
    checkOutput("s1_model_done", exp_done, 1'b1);
    base = writes_seen;
    applyStimulus(1'b0);
    check_outcome("s1");
    checkOutput("s1_cpu_reset", cpu_reset, 1'b0);
    checkOutput("s1_writes", writes_seen - base, 1);
    checkOutput("s1_addr", last_addr, 0);
    checkOutput("s1_data", last_data, 32'h12345678);
    pulse_start();

    $display("[TB] bad checksum");
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    build_model();
    checkOutput("s2_model_error", exp_error, 1'b1);
    base = writes_seen;
    applyStimulus(1'b0);
    check_outcome("s2");
    checkOutput("s2_error", error, 1'b1);
    checkOutput("s2_cpu_reset", cpu_reset, 1'b1);
    checkOutput("s2_writes", writes_seen - base, 1);
    pulse_start();

    $display("[TB] oversize");
    frame = '{8'h01, 8'h10};
    build_model();
    base = writes_seen;
    applyStimulus(1'b0);
    checkOutput("s3_error_next_cycle", error, 1'b1);
    checkOutput("s3_in_ready", in_ready, 1'b0);
    check_outcome("s3");
    checkOutput("s3_writes", writes_seen - base, 0);
    pulse_start();

    $display("[TB] empty image");
    frame = '{8'h00, 8'h00, 8'h00};
    build_model();
    base = writes_seen;
    applyStimulus(1'b0);
    check_outcome("s4");
    checkOutput("s4_done", done, 1'b1);
    checkOutput("s4_cpu_reset", cpu_reset, 1'b0);
    checkOutput("s4_writes", writes_seen - base, 0);
    pulse_start();

    for (int g = 0; g < 2; g++) begin
      $display("[TB] two words, gapped=%0d", g);
      frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hFB};
      build_model();
      checkOutput("s5_model_word0", exp_writes[0], 32'h00000001);
      base = writes_seen;
      applyStimulus(g == 1);
      check_outcome("s5");
      checkOutput("s5_done", done, 1'b1);
      checkOutput("s5_writes", writes_seen - base, 2);
      checkOutput("s5_last_addr", last_addr, 1);
      checkOutput("s5_last_data", last_data, 32'h00000002);
      pulse_start();
    end

    $display("[TB] reset mid-frame");
    frame = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    exp_writes.delete();
    exp_addrs.delete();
    base = writes_seen;
    applyStimulus(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("s6_in_ready", in_ready, 1'b1);
    checkOutput("s6_busy", busy, 1'b1);
    checkOutput("s6_cpu_reset", cpu_reset, 1'b1);
    checkOutput("s6_mem_addr", mem_addr, 0);
    checkOutput("s6_writes", writes_seen - base, 0);
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEB};
    build_model();
    base = writes_seen;
    applyStimulus(1'b0);
    check_outcome("s6_reload");
    checkOutput("s6_reload_writes", writes_seen - base, 1);
    checkOutput("s6_reload_data", last_data, 32'h12345678);
    pulse_start();

    $display("[TB] maximum image");
    frame = '{8'h00, 8'h10};
    for (int i = 0; i < MAX_WORDS; i++) begin
      logic [11:0] iv;
      iv = 12'(i);
      frame.push_back(iv[7:0]);
      frame.push_back({4'h0, iv[11:8]});
      frame.push_back(8'h5A);
      frame.push_back(~iv[7:0]);
    end
    s = 8'h00;
    foreach (frame[k]) s = s + frame[k];
    frame.push_back(8'h00 - s);
    build_model();
    checkOutput("s7_model_count", exp_writes.size(), MAX_WORDS);
    base = writes_seen;
    applyStimulus(1'b0);
    check_outcome("s7");
    checkOutput("s7_done", done, 1'b1);
    checkOutput("s7_writes", writes_seen - base, MAX_WORDS);
    checkOutput("s7_last_addr", last_addr, MAX_WORDS - 1);
    checkOutput("s7_last_data", last_data, 32'h005A0FFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the CPU top level. Receives a framed program image as a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word through one memory write port; the top level fans that port to both instruction and data memory.
- Holds the CPU in reset until the whole image has loaded and its checksum verifies. Replaces backdoor memory preload for FPGA and bring-up use.

Parameters:
ADDR_WIDTH, 12, word-address width; maximum image size is 2**ADDR_WIDTH words (4096).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader accepts a byte this cycle
start  input  1  one-cycle pulse; re-arms the loader from DONE or ERR
mem_we  output  1  one-cycle word-write strobe
mem_addr  output  ADDR_WIDTH  word address, 0-based
mem_wdata  output  32  assembled word
cpu_reset  output  1  CPU reset; high until load succeeds
busy  output  1  frame in progress (LEN0..SUM)
done  output  1  load succeeded
error  output  1  load failed (oversize or checksum)

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Handshake: a byte transfers on a rising clk edge with in_valid && in_ready. in_ready is combinational from state only: 1 in LEN0, LEN1, DATA and SUM; 0 in DONE and ERR.
- Frame format: LEN_LO, LEN_HI, then 4*LEN data bytes, then one checksum byte.
  - Data bytes are little-endian within a word: the first byte is bits 7:0.
  - The mod-256 sum of every frame byte, including the length bytes and the checksum byte, must equal 0x00.
- FSM states: LEN0, LEN1, DATA, SUM, DONE, ERR.
  - Reset: state LEN0, cpu_reset=1, busy=1, mem_we=0, done=0, error=0, mem_addr=0, mem_wdata=0, sum=0, byte counter=0.
  - LEN0 on accept: store low length byte, go to LEN1.
  - LEN1 on accept, full 16-bit LEN > 2**ADDR_WIDTH: go to ERR.
  - LEN1 on accept, LEN==0: go to SUM.
  - LEN1 on accept, otherwise: go to DATA.
  - DATA: 2-bit byte lane counter. On the 4th accepted byte, the next cycle has mem_we=1, mem_wdata = assembled word, mem_addr = word index. After each 4th byte the word index increments. When it reaches LEN, go to SUM.
  - SUM on accept: if the running sum plus this byte is 0x00 mod 256, go to DONE; otherwise go to ERR.
  - DONE: done=1, cpu_reset=0, busy=0.
  - ERR: error=1, cpu_reset=1, busy=0.
  - DONE or ERR with start=1: clear state exactly as reset does; cpu_reset=1 in the next cycle.
  - start is ignored in LEN0..SUM.
- Write pulse: mem_we is registered and high for exactly one cycle per word. Input accepts never stall, because each write takes one cycle and the next word needs at least 4 accepts.
- Gaps: cycles with in_valid=0 change no state and leave the sum and lane counter unchanged.
- Reset mid-frame: the partial word is discarded and no write issues. The loader returns to LEN0 with cpu_reset=1.
- The maximum image of 2**ADDR_WIDTH words is legal. mem_addr never wraps.
- done and error are never high together.

Decomposition:
- Package loader_pkg holds:
  - the state enum (LEN0, LEN1, DATA, SUM, DONE, ERR);
  - the constant BYTES_PER_WORD=4;
  - the constant CHECKSUM_OK=8'h00.
- Sub-module word_assembler: shifts bytes into a 32-bit word, keeps the 2-bit lane count, and raises word_valid on the 4th byte, with clear. The FSM, length handling and checksum stay in program_loader.

Test Plan:
1. Single word: stream 01 00 78 56 34 12 EB with in_valid held high.
   - Exactly one mem_we pulse: addr 0, data 0x12345678.
   - Then done=1 and cpu_reset=0; in_ready=0 afterwards.
2. Bad checksum: same frame with EC as the final byte.
   - One write still occurs; then error=1, cpu_reset stays 1, done=0.
   - A start pulse returns the loader to LEN0 with busy=1.
3. Oversize: stream 01 10 (LEN=0x1001).
   - error=1 one cycle after the 2nd accepted byte; no mem_we; in_ready=0.
4. Empty image: stream 00 00 00.
   - No writes; done=1 and cpu_reset=0.
5. Gapped stream: two words, bytes 02 00 | 01 00 00 00 | 02 00 00 00 | FB, with in_valid low on alternate cycles.
   - Writes addr 0 = 0x00000001 and addr 1 = 0x00000002, then done=1.
   - Result is identical to the gapless run.
6. Reset mid-frame: assert reset after 02 00 AA BB are accepted.
   - No write; state LEN0, cpu_reset=1.
   - A subsequent full scenario-1 frame loads correctly.
